// File: rtl/llfifo_pkg.sv
// Shared types for the linked-list FIFO controller and its egress scheduler.
// Queue ids, SRAM pointers and the egress buffer entry live here.
package llfifo_pkg;

  localparam int ID_N       = 4;
  localparam int PTR_N      = 16;
  localparam int ID_W       = $clog2(ID_N);
  localparam int PTR_W      = $clog2(PTR_N);
  localparam int EG_W       = 32;
  localparam int OBUF_N_DEF = 2;

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    id_t             id;
    logic [EG_W-1:0] data;
  } egress_t;

  function automatic id_t id_next(input id_t i);
    if (i == id_t'(ID_N - 1)) return '0;
    return i + 1'b1;
  endfunction

endpackage

// File: rtl/llfifo_rr_arb.sv
// Round-robin arbiter: grants the first request strictly after ptr,
// wrapping modulo ID_N; gives one-hot and encoded grant.
module llfifo_rr_arb
  import llfifo_pkg::*;
(
  input  logic [ID_N-1:0] req,
  input  id_t             ptr,
  output logic [ID_N-1:0] gnt_oh,
  output id_t             gnt_id
);

  always_comb begin
    id_t  idx;
    logic found;
    gnt_oh = '0;
    gnt_id = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < ID_N; k++) begin
      idx = id_next(idx);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt_id      = idx;
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/llfifo_egress_sched.sv
// Pop-side scheduler: round-robin pop issue, one-cycle SRAM read capture
// and a credit-protected egress FIFO on a valid/ready port.
module llfifo_egress_sched
  import llfifo_pkg::*;
#(
  parameter int W      = EG_W,
  parameter int OBUF_N = OBUF_N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [ID_N-1:0] en_mask,
  input  logic [ID_N-1:0] nempty_r,
  input  logic            busy_r,
  input  logic            ingress_req,
  output logic            pop_pass,
  output id_t             pop_id,
  input  ptr_t            cmd_pop_ptr_w,
  output logic            dram_en,
  output ptr_t            dram_addr,
  input  logic [W-1:0]    dram_dout,
  output logic            out_vld,
  input  logic            out_rdy,
  output id_t             out_id,
  output logic [W-1:0]    out_data
);

  localparam int AW = $clog2(OBUF_N);
  localparam int CW = AW + 1;

  logic [ID_N-1:0] elig;
  logic [ID_N-1:0] gnt_oh;
  id_t             gnt_id;
  id_t             rr_ptr;
  logic            gnt_vld;
  logic            room;
  logic            issue;
  logic            inflight;
  id_t             inflight_id;
  logic            wr;
  logic            rd;

  egress_t         buf_q [OBUF_N];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;

  assign elig = nempty_r & en_mask;

  llfifo_rr_arb u_arb (
    .req    (elig),
    .ptr    (rr_ptr),
    .gnt_oh (gnt_oh),
    .gnt_id (gnt_id)
  );

  assign gnt_vld = |gnt_oh;

  // A read in flight holds a buffer slot until it lands.
  assign room  = (occ + CW'(inflight)) < CW'(OBUF_N);

  assign issue = gnt_vld & ~busy_r & ~ingress_req
               & ~clear & ~rst & room;

  assign pop_pass  = issue;
  assign pop_id    = gnt_id;
  assign dram_en   = issue;
  assign dram_addr = cmd_pop_ptr_w;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rr_ptr      <= id_t'(ID_N - 1);
      inflight    <= 1'b0;
      inflight_id <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rr_ptr      <= gnt_id;
        inflight_id <= gnt_id;
      end
    end
  end

  assign wr = inflight & ~clear & ~rst;
  assign rd = out_vld & out_rdy;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)      occ <= occ + 1'b1;
      else if (!wr && rd) occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      buf_q[wr_ptr].id   <= inflight_id;
      buf_q[wr_ptr].data <= EG_W'(dram_dout);
    end
  end

  assign out_vld  = (occ != '0);
  assign out_id   = buf_q[rd_ptr].id;
  assign out_data = W'(buf_q[rd_ptr].data);

endmodule
